// File: rtl/spi_master_shifter.sv
// spi_master_shifter: master-mode SPI engine, one 8-bit full-duplex transfer
// per start request. SCK is derived from clk through a fixed half-period
// divider (DIV clk cycles per SCK edge). Mode bits are latched at start so
// the control register may change freely while a transfer is in flight.
module spi_master_shifter #(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPE,
  input  logic       MSTR,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic       LSBFE,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       MISO,
  output logic       SCK,
  output logic       MOSI,
  output logic       SS_n,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Terminal value of the divider; one SCK edge (or the SS_n hold) per wrap.
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] div_cnt;
  logic [4:0] edge_cnt;       // SCK edges done so far, 0..16
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] rx_data_reg;
  logic       sck_reg;
  logic       cpol_l;
  logic       cpha_l;
  logic       lsbfe_l;

  logic       start;
  logic       abort;
  logic       tick;
  logic       edge_now;
  logic       sample_now;
  logic       advance_now;

  assign start = SPE & MSTR & tx_valid;
  assign abort = ~(SPE & MSTR);
  assign tick  = (div_cnt == DIV_LAST);

  // An SCK edge fires when the divider wraps and edges remain; edge k = edge_cnt.
  assign edge_now    = (state == ACTIVE) && !abort && tick && (edge_cnt != 5'd16);
  // Sampling edges are the leading ones for CPHA=0 and trailing ones for CPHA=1.
  assign sample_now  = edge_now && (edge_cnt[0] == cpha_l);
  // MOSI moves on the opposite edge type, never before the first or after the last bit.
  assign advance_now = edge_now && (edge_cnt[0] != cpha_l) &&
                       (edge_cnt != 5'd0) && (edge_cnt != 5'd15);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: abort wins over completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACTIVE;
      ACTIVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick && (edge_cnt == 5'd16)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the current state and the transmit shifter.
  always_comb begin
    SS_n     = 1'b1;
    busy     = 1'b0;
    rx_valid = 1'b0;
    MOSI     = 1'b0;
    case (state)
      ACTIVE: begin
        SS_n = 1'b0;
        busy = 1'b1;
        MOSI = lsbfe_l ? tx_shift[0] : tx_shift[7];
      end
      DONE:    rx_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: divider, edge counter, SCK generation and both shift registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt     <= 8'd0;
      edge_cnt    <= 5'd0;
      tx_shift    <= 8'd0;
      rx_shift    <= 8'd0;
      rx_data_reg <= 8'd0;
      sck_reg     <= 1'b0;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      lsbfe_l     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sck_reg  <= CPOL;
          div_cnt  <= 8'd0;
          edge_cnt <= 5'd0;
          if (start) begin
            tx_shift <= tx_data;
            rx_shift <= 8'd0;
            cpol_l   <= CPOL;
            cpha_l   <= CPHA;
            lsbfe_l  <= LSBFE;
          end
        end
        ACTIVE: begin
          if (abort) begin
            sck_reg <= CPOL;
          end else begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            if (edge_now) begin
              sck_reg  <= ~sck_reg;
              edge_cnt <= edge_cnt + 5'd1;
            end
            if (sample_now) begin
              rx_shift <= lsbfe_l ? {MISO, rx_shift[7:1]} : {rx_shift[6:0], MISO};
            end
            if (advance_now) begin
              tx_shift <= lsbfe_l ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
            end
            if (state_next == DONE) begin
              rx_data_reg <= rx_shift;
            end
          end
        end
        DONE: begin
          // Sixteen toggles leave SCK at the latched idle level; hold it there.
          sck_reg <= cpol_l;
        end
        default: ;
      endcase
    end
  end

  assign SCK     = sck_reg;
  assign rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter: a table of directed transfers
// on a DIV=2 and a DIV=1 instance, plus hand-written sequences for held
// tx_valid, abort and mid-transfer reset.
module tb_spi_master_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SPE = 1'b0;
  logic       MSTR = 1'b0;
  logic       CPOL = 1'b0;
  logic       CPHA = 1'b0;
  logic       LSBFE = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tv1 = 1'b0;
  logic       tv2 = 1'b0;
  logic       miso_drv = 1'b0;
  logic       loop = 1'b0;
  logic       sel1 = 1'b0;

  logic       sck_1, mosi_1, ss_1, busy_1, rxv_1;
  logic [7:0] rxd_1;
  logic       sck_2, mosi_2, ss_2, busy_2, rxv_2;
  logic [7:0] rxd_2;
  logic       miso_2;

  logic       sck_m, mosi_m, ss_m, busy_m, rxv_m;
  logic [7:0] rxd_m;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign miso_2 = loop ? mosi_2 : miso_drv;

  assign sck_m  = sel1 ? sck_1  : sck_2;
  assign mosi_m = sel1 ? mosi_1 : mosi_2;
  assign ss_m   = sel1 ? ss_1   : ss_2;
  assign busy_m = sel1 ? busy_1 : busy_2;
  assign rxv_m  = sel1 ? rxv_1  : rxv_2;
  assign rxd_m  = sel1 ? rxd_1  : rxd_2;

  spi_master_shifter #(.DIV(2)) u_dut (
    .clk(clk), .rst(rst), .SPE(SPE), .MSTR(MSTR), .CPOL(CPOL), .CPHA(CPHA),
    .LSBFE(LSBFE), .tx_data(tx_data), .tx_valid(tv2), .MISO(miso_2),
    .SCK(sck_2), .MOSI(mosi_2), .SS_n(ss_2), .busy(busy_2),
    .rx_data(rxd_2), .rx_valid(rxv_2)
  );

  spi_master_shifter #(.DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .SPE(SPE), .MSTR(MSTR), .CPOL(CPOL), .CPHA(CPHA),
    .LSBFE(LSBFE), .tx_data(tx_data), .tx_valid(tv1), .MISO(miso_drv),
    .SCK(sck_1), .MOSI(mosi_1), .SS_n(ss_1), .busy(busy_1),
    .rx_data(rxd_1), .rx_valid(rxv_1)
  );

  // mmode: 0 = MISO looped from MOSI, 1 = MISO plays miso_seq (bit7 first), 2 = MISO held 0
  typedef struct {
    bit         d1;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] tx;
    int         mmode;
    logic [7:0] miso_seq;
    logic [7:0] exp_seq;   // bits seen on MOSI in wire order, first bit in bit7
    logic [7:0] exp_rx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Follows a transfer from its first ACTIVE cycle until rx_valid or a cycle budget.
  task automatic watch(input int div, input logic cpha_e, input bit pat, input logic [7:0] pat_seq,
                       input int change_at, output int got, output int toggles,
                       output logic [7:0] seq, output logic ss_at, output logic busy_at);
    logic prev_sck;
    logic prev_mosi;
    int   idx;
    got = -1; toggles = 0; seq = 8'd0; ss_at = 1'b0; busy_at = 1'b1; idx = 1;
    prev_sck = sck_m; prev_mosi = mosi_m;
    for (int n = 1; n <= 17 * div + 4 && got < 0; n++) begin
      @(posedge clk); #1;
      if (n == change_at) begin
        tx_data = 8'hC3;
        CPHA    = ~CPHA;
      end
      if (sck_m !== prev_sck) begin
        if (toggles[0] == cpha_e) seq = {seq[6:0], prev_mosi};
        if (pat && (toggles[0] != cpha_e) && toggles != 0 && idx < 8) begin
          miso_drv = pat_seq[7 - idx];
          idx++;
        end
        toggles++;
      end
      if (rxv_m === 1'b1) begin
        got = n; ss_at = ss_m; busy_at = busy_m;
      end
      prev_sck = sck_m; prev_mosi = mosi_m;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int div, got, tog;
    logic [7:0] seq;
    logic ss_at, busy_at;
    div = v.d1 ? 1 : 2;
    sel1 = v.d1; loop = (v.mmode == 0);
    miso_drv = (v.mmode == 1) ? v.miso_seq[7] : 1'b0;
    CPOL = v.cpol; CPHA = v.cpha; LSBFE = v.lsbfe; tx_data = v.tx; SPE = 1'b1; MSTR = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_sck"}, sck_m, v.cpol);
    check({tag, "_idle_ss"}, ss_m, 1'b1);
    if (v.d1) tv1 = 1'b1; else tv2 = 1'b1;
    @(posedge clk); #1;
    tv1 = 1'b0; tv2 = 1'b0;
    check({tag, "_start_ss"}, ss_m, 1'b0);
    check({tag, "_start_busy"}, busy_m, 1'b1);
    watch(div, v.cpha, v.mmode == 1, v.miso_seq, -1, got, tog, seq, ss_at, busy_at);
    check({tag, "_latency"}, got, 17 * div);
    check({tag, "_toggles"}, tog, 16);
    check({tag, "_mosi_seq"}, seq, v.exp_seq);
    check({tag, "_rx_data"}, rxd_m, v.exp_rx);
    check({tag, "_done_ss"}, ss_at, 1'b1);
    check({tag, "_done_busy"}, busy_at, 1'b0);
    @(posedge clk); #1;
    check({tag, "_rxv_width"}, rxv_m, 1'b0);
    check({tag, "_after_sck"}, sck_m, v.cpol);
    miso_drv = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int got, tog, nrx;
    logic [7:0] seq;
    logic ss_at, busy_at, prev;

    //            d1 cpol cpha lsbfe tx    mmode miso   seq    rx
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1, 8'h69, 8'h3C, 8'h96};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 2, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 2, 8'h00, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h6B, 0, 8'h00, 8'h6B, 8'h6B};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h1E, 0, 8'h00, 8'h78, 8'h1E};

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b0;
    #1;
    sel1 = 1'b0;
    check("reset_sck", sck_m, 1'b0);
    check("reset_mosi", mosi_m, 1'b0);
    check("reset_ss", ss_m, 1'b1);
    check("reset_busy", busy_m, 1'b0);
    check("reset_rxv", rxv_m, 1'b0);
    check("reset_rxd", rxd_m, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      $display("vec %0d: tx=0x%02h rx=0x%02h", i, vecs[i].tx, rxd_m);
    end

    // tx_valid held high; tx_data and CPHA change mid-transfer.
    sel1 = 1'b0; loop = 1'b1; CPOL = 1'b0; CPHA = 1'b0; LSBFE = 1'b0; tx_data = 8'h5A;
    SPE = 1'b1; MSTR = 1'b1;
    @(posedge clk); #1;
    tv2 = 1'b1;
    @(posedge clk); #1;
    watch(2, 1'b0, 1'b0, 8'h00, 5, got, tog, seq, ss_at, busy_at);
    check("hold_latency", got, 34);
    check("hold_seq", seq, 8'h5A);
    check("hold_rx", rxd_m, 8'h5A);
    @(posedge clk); #1;
    check("hold_gap_ss", ss_m, 1'b1);
    check("hold_gap_busy", busy_m, 1'b0);
    @(posedge clk); #1;
    tv2 = 1'b0;
    check("hold_restart_busy", busy_m, 1'b1);
    watch(2, 1'b1, 1'b0, 8'h00, -1, got, tog, seq, ss_at, busy_at);
    check("hold2_latency", got, 34);
    check("hold2_seq", seq, 8'hC3);
    check("hold2_rx", rxd_m, 8'hC3);
    $display("held tx_valid: second rx=0x%02h", rxd_m);
    @(posedge clk); #1;

    // Abort by dropping SPE right after SCK edge k=6.
    CPOL = 1'b0; CPHA = 1'b0; LSBFE = 1'b0; tx_data = 8'h33;
    @(posedge clk); #1;
    tv2 = 1'b1;
    @(posedge clk); #1;
    tv2 = 1'b0;
    tog = 0; prev = sck_m;
    for (int n = 0; n < 40 && tog < 7; n++) begin
      @(posedge clk); #1;
      if (sck_m !== prev) tog++;
      prev = sck_m;
    end
    check("abort_reach_k6", tog, 7);
    SPE = 1'b0;
    @(posedge clk); #1;
    check("abort_ss", ss_m, 1'b1);
    check("abort_busy", busy_m, 1'b0);
    check("abort_sck", sck_m, 1'b0);
    check("abort_mosi", mosi_m, 1'b0);
    SPE = 1'b1;
    nrx = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rxv_m === 1'b1) nrx++;
    end
    check("abort_no_rxv", nrx, 0);
    check("abort_rx_kept", rxd_m, 8'hC3);
    $display("abort: rx_data=0x%02h", rxd_m);

    // Reset pulsed mid-transfer, then a clean transfer.
    CPOL = 1'b1; CPHA = 1'b1; LSBFE = 1'b1; tx_data = 8'h81;
    @(posedge clk); #1;
    tv2 = 1'b1;
    @(posedge clk); #1;
    tv2 = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_sck", sck_m, 1'b0);
    check("rst_mid_ss", ss_m, 1'b1);
    check("rst_mid_busy", busy_m, 1'b0);
    check("rst_mid_mosi", mosi_m, 1'b0);
    check("rst_mid_rxd", rxd_m, 8'h00);
    check("rst_mid_rxv", rxv_m, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_vec('{1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 0, 8'h00, 8'h81, 8'h81}, "post_rst");
    $display("post reset: rx_data=0x%02h", rxd_m);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_shifter.md
# spi_master_shifter

Master-mode SPI transfer engine that consumes the control bits produced by the SPI control register (SPE, MSTR, CPOL, CPHA, LSBFE) and performs one 8-bit full-duplex transfer per start request. It generates SCK from the system clock through a fixed divider and drives SS_n and MOSI. It samples MISO and returns the received byte with a one-cycle completion strobe. It sits directly downstream of the control register and upstream of the data/status registers.

## Interface
- DIV, default 2: SCK half-period in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- SPE  in  1  SPI enable from control register.
- MSTR  in  1  master select from control register; engine runs only when 1.
- CPOL  in  1  SCK idle level.
- CPHA  in  1  clock phase: 0 = sample on leading edges, 1 = sample on trailing edges.
- LSBFE  in  1  1 = LSB first, 0 = MSB first.
- tx_data  in  8  byte to transmit; captured at start.
- tx_valid  in  1  start request; honoured only in IDLE.
- MISO  in  1  serial input.
- SCK  out  1  serial clock.
- MOSI  out  1  serial output.
- SS_n  out  1  slave select, active low.
- busy  out  1  transfer in progress; tx_ready = ~busy.
- rx_data  out  8  last completed received byte.
- rx_valid  out  1  one-cycle strobe when rx_data updates.

## Operation
- Reset values, asserted immediately on rst=0: SCK=0, MOSI=0, SS_n=1, busy=0, rx_valid=0, rx_data=0x00, state IDLE, edge counter 0.
- States: IDLE -> ACTIVE -> DONE -> IDLE.
- IDLE
  - SCK is a registered copy of CPOL, updated every cycle.
  - MOSI=0, SS_n=1, busy=0.
  - Start condition: SPE & MSTR & tx_valid.
  - On start: latch tx_data, CPOL, CPHA and LSBFE. The latched copies govern the whole transfer; later input changes are ignored. Go to ACTIVE.
- ACTIVE
  - SS_n=0, busy=1.
  - MOSI presents the first bit (tx_data[7] if LSBFE=0, tx_data[0] if LSBFE=1) from the first ACTIVE cycle.
  - A divider counts DIV cycles per SCK edge; 16 edges, numbered k=0..15. SCK toggles on each edge; even k are leading edges, odd k are trailing edges.
  - Sample edges: CPHA=0 -> k=0,2,..,14; CPHA=1 -> k=1,3,..,15. MISO is captured on the same clk edge on which SCK toggles.
  - MOSI advances to the next bit on: CPHA=0 -> k=1,3,..,13; CPHA=1 -> k=2,4,..,14.
  - Receive assembly: LSBFE=0 shifts in at bit0, so the first bit ends in rx bit7. LSBFE=1 shifts in at bit7, so the first bit ends in rx bit0.
  - After k=15, SCK equals the latched CPOL. Hold SS_n=0 for DIV more cycles, then go to DONE.
- DONE (single cycle)
  - SS_n=1, busy=0, rx_data = assembled byte, rx_valid=1.
  - Return to IDLE.
- Abort: SPE=0 or MSTR=0 sampled during ACTIVE.
  - Next cycle: state IDLE, SS_n=1, busy=0, SCK = CPOL, MOSI=0.
  - No rx_valid is produced; rx_data is unchanged.
- tx_valid asserted while busy=1 is ignored; there is no queue.
- Async reset asserted mid-transfer forces the reset values at once; no rx_valid is produced.

## Timing
- Start accepted at rising edge T0 (IDLE with start condition true).
- T0+1: SS_n=0, busy=1, first bit on MOSI.
- Edge k occurs at T0+1+(k+1)*DIV.
- DONE cycle (rx_valid=1, SS_n=1, busy=0) at T0+1+17*DIV.
- The earliest next start is accepted in the cycle after DONE. Back-to-back transfers have SS_n high for at least 1 cycle.
- SCK period = 2*DIV clk cycles; duty cycle exactly 50%.
- DIV=1: SCK toggles every cycle and the latency formula still holds.

## Test plan
- Mode 0 (CPOL=0, CPHA=0), LSBFE=0, DIV=2, tx_data=0xA5, MISO tied to MOSI -> MOSI sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; rx_valid pulse at T0+35; SCK idles at 0.
- Mode 3 (CPOL=1, CPHA=1), LSBFE=1, DIV=2, tx_data=0x3C, MISO driven with serial stream of 0x96 LSB first -> MOSI 0,0,1,1,1,1,0,0; rx_data=0x96; SCK idles at 1 before and after the transfer.
- Modes 1 and 2 with DIV=1, tx_data=0xFF, MISO=0 -> rx_data=0x00; exactly 16 SCK toggles; rx_valid at T0+18.
- tx_valid held high through a transfer, with tx_data changed and CPHA toggled mid-transfer -> no effect on the current transfer; a second transfer starts in the cycle after DONE with the new tx_data.
- SPE dropped at edge k=6 -> next cycle SS_n=1, busy=0; no rx_valid; rx_data keeps its previous value.
- rst pulsed low mid-transfer -> outputs take reset values within the same cycle; a new start after release completes normally.
